// File: rtl/tt_vector_checker_if.sv
// rtl/tt_vector_checker_if.sv - run control, stimulus and result bundle of the truth-table checker
interface tt_vector_checker_if #(
  parameter int N_IN = 3
);
  logic            start;
  logic [N_IN-1:0] vec_out;
  logic            vec_valid;
  logic            resp_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            first_fail_valid;
  logic [N_IN-1:0] first_fail_idx;

  // Controller side: requests runs, returns the block-under-test response, reads results
  modport master (
    output start, resp_in,
    input  vec_out, vec_valid, busy, done, pass, err_count, first_fail_valid, first_fail_idx
  );

  // Checker side
  modport slave (
    input  start, resp_in,
    output vec_out, vec_valid, busy, done, pass, err_count, first_fail_valid, first_fail_idx
  );
endinterface

// File: rtl/tt_vector_checker.sv
// rtl/tt_vector_checker.sv - Gray-order exhaustive vector driver and truth-table response checker
module tt_vector_checker #(
  parameter int                 N_IN     = 3,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'h3F,
  parameter int                 SETTLE   = 1
) (
  input  logic            clk,
  input  logic            reset,
  tt_vector_checker_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_DONE} state_t;

  localparam logic [N_IN-1:0] LAST_STEP = {N_IN{1'b1}};
  localparam logic [3:0]      SETTLE_H  = 4'(SETTLE);

  state_t          state;
  state_t          state_nxt;
  logic [N_IN-1:0] step;
  logic [3:0]      hold;
  logic [N_IN:0]   err_q;
  logic            ffv_q;
  logic [N_IN-1:0] ffi_q;

  logic [N_IN-1:0] gray;
  logic            driving;
  logic            accept;
  logic            sample;
  logic            last;
  logic            mismatch;

  // Adjacent steps differ in one bit, so the block under test sees single-input transitions
  assign gray     = step ^ (step >> 1);
  assign driving  = (state == ST_DRIVE);
  // A start while a run is in progress is deliberately dropped
  assign accept   = !driving && bus.start;
  assign sample   = driving && (hold == SETTLE_H);
  assign last     = (step == LAST_STEP);
  assign mismatch = (bus.resp_in != EXPECTED[gray]);

  // State register; reset aborts any run in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: start launches a run from idle or done, the final sample ends it
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_DRIVE;
      ST_DRIVE: if (sample && last) state_nxt = ST_DONE;
      ST_DONE:  if (bus.start) state_nxt = ST_DRIVE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Step/hold sequencing and result accumulation; results persist in DONE until restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step  <= '0;
      hold  <= '0;
      err_q <= '0;
      ffv_q <= 1'b0;
      ffi_q <= '0;
    end else if (accept) begin
      step  <= '0;
      hold  <= '0;
      err_q <= '0;
      ffv_q <= 1'b0;
      ffi_q <= '0;
    end else if (driving) begin
      if (!sample) begin
        hold <= hold + 4'd1;
      end else begin
        if (mismatch) begin
          // At most 2**N_IN mismatches per run, which fits N_IN+1 bits
          err_q <= err_q + (N_IN+1)'(1);
          if (!ffv_q) begin
            ffv_q <= 1'b1;
            ffi_q <= gray;
          end
        end
        if (!last) begin
          step <= step + N_IN'(1);
          hold <= '0;
        end
      end
    end
  end

  assign bus.busy             = driving;
  assign bus.vec_valid        = driving;
  assign bus.vec_out          = driving ? gray : '0;
  assign bus.done             = (state == ST_DONE);
  assign bus.pass             = (state == ST_DONE) && (err_q == '0);
  assign bus.err_count        = err_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_tt_vector_checker.sv
// tb/tb_tt_vector_checker.sv - table-driven and scoreboard bench for tt_vector_checker
module tb_tt_vector_checker;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tt_vector_checker_if #(.N_IN(3)) bus_a ();
  tt_vector_checker_if #(.N_IN(3)) bus_b ();

  tt_vector_checker #(.N_IN(3), .EXPECTED(8'h3F), .SETTLE(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  tt_vector_checker #(.N_IN(3), .EXPECTED(8'h3F), .SETTLE(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  typedef struct {
    int mode;      // 0 reference function, 1 stuck-at-1, 2 stuck-at-0
    bit poke;      // extra start pulses during the run
    int exp_err;
    int exp_ffv;
    int exp_ffi;
    int exp_pass;
  } vec_t;

  vec_t       tab [3];
  logic [2:0] gray_tab [8];
  logic [2:0] exp_q [$];
  int         passed = 0;
  int         total  = 0;

  function automatic logic ref_fn(input logic [2:0] v);
    logic a, c, b;
    a = v[2];
    c = v[1];
    b = v[0];
    return !(a && c) || !(b || c);
  endfunction

  function automatic logic resp_for(input int mode, input logic [2:0] v);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    return ref_fn(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bus_a.busy, bus_a.vec_valid, bus_a.done, bus_a.pass, bus_a.first_fail_valid,
                 bus_a.vec_out, bus_a.err_count, bus_a.first_fail_idx}, 0);
  endtask

  // Called just after a falling edge; returns just after a falling edge
  task automatic run_a(input int idx);
    vec_t       v;
    logic [2:0] exp_v;
    v = tab[idx];
    bus_a.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++)
      for (int h = 0; h < 2; h++) exp_q.push_back(gray_tab[k]);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      bus_a.start   = v.poke && (c == 5 || c == 9);
      bus_a.resp_in = resp_for(v.mode, bus_a.vec_out);
      exp_v = exp_q.pop_front();
      check("vec_out", bus_a.vec_out, exp_v);
      check("valid_busy_done", {bus_a.vec_valid, bus_a.busy, bus_a.done}, 3'b110);
    end
    bus_a.start = 1'b0;
    @(negedge clk);
    check("end_valid_busy_done", {bus_a.vec_valid, bus_a.busy, bus_a.done}, 3'b001);
    check("end_vec_out", bus_a.vec_out, 0);
    check("err_count", bus_a.err_count, v.exp_err);
    check("first_fail_valid", bus_a.first_fail_valid, v.exp_ffv);
    check("first_fail_idx", bus_a.first_fail_idx, v.exp_ffi);
    check("pass", bus_a.pass, v.exp_pass);
  endtask

  initial begin
    gray_tab[0] = 3'd0; gray_tab[1] = 3'd1; gray_tab[2] = 3'd3; gray_tab[3] = 3'd2;
    gray_tab[4] = 3'd6; gray_tab[5] = 3'd7; gray_tab[6] = 3'd5; gray_tab[7] = 3'd4;
    tab[0] = '{mode: 0, poke: 1'b0, exp_err: 0, exp_ffv: 0, exp_ffi: 0, exp_pass: 1};
    tab[1] = '{mode: 1, poke: 1'b0, exp_err: 2, exp_ffv: 1, exp_ffi: 6, exp_pass: 0};
    tab[2] = '{mode: 2, poke: 1'b1, exp_err: 6, exp_ffv: 1, exp_ffi: 0, exp_pass: 0};

    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.resp_in = 1'b0;
    bus_b.start = 1'b0; bus_b.resp_in = 1'b0;
    #1;
    check_all_zero("reset_state");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    // Golden, stuck-at-1, stuck-at-0 with ignored starts; each later run restarts from DONE
    for (int i = 0; i < 3; i++) run_a(i);

    // Reset in the middle of step 3 with three errors already counted
    bus_a.start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      bus_a.start   = 1'b0;
      bus_a.resp_in = 1'b0;
    end
    check("mid_vec_out", bus_a.vec_out, 2);
    check("mid_err_count", bus_a.err_count, 3);
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    @(negedge clk);
    check_all_zero("held_reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_abort");
    run_a(0);

    // SETTLE=0: one cycle per vector, single-cycle glitch on the vec_out=7 vector
    bus_b.start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus_b.start = 1'b0;
      check("s0_vec_out", bus_b.vec_out, gray_tab[c]);
      check("s0_valid_busy_done", {bus_b.vec_valid, bus_b.busy, bus_b.done}, 3'b110);
      bus_b.resp_in = (c == 5) ? !ref_fn(bus_b.vec_out) : ref_fn(bus_b.vec_out);
    end
    @(negedge clk);
    check("s0_done", {bus_b.vec_valid, bus_b.busy, bus_b.done}, 3'b001);
    check("s0_err_count", bus_b.err_count, 1);
    check("s0_first_fail_valid", bus_b.first_fail_valid, 1);
    check("s0_first_fail_idx", bus_b.first_fail_idx, 7);
    check("s0_pass", bus_b.pass, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tt_vector_checker.md
Name: tt_vector_checker

Overview:
- Self-test engine for small combinational Boolean blocks: drives every input vector onto a DUT and checks the DUT's 1-bit response against a golden truth table.
- Steps through the vectors in reflected Gray-code order: 0,1,3,2,6,7,5,4 for 3 inputs.
- Counts mismatches, records the first failing vector, and reports pass/fail.
- Synthesizable stimulus/check counterpart to the team's 3-input logic-function modules. Sits beside the DUT: vec_out feeds the DUT inputs, and the DUT output returns on resp_in.

Parameters:
- N_IN, 3: number of DUT inputs; 2**N_IN vectors per run; valid range 1..6.
- EXPECTED, 8'h3F: golden truth table, width 2**N_IN. Bit k is the required response when vec_out == k. The default matches s = !(a&c) || !(b||c) with vec_out = {a,c,b}.
- SETTLE, 1: extra cycles each vector is held before sampling; valid range 0..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a run; honoured only when busy==0
- vec_out  output  N_IN  stimulus vector to the DUT
- vec_valid  output  1  high while vec_out is being applied
- resp_in  input  1  DUT response; sampled only at the end of each vector's hold window
- busy  output  1  run in progress
- done  output  1  run finished; held until the next accepted start or reset
- pass  output  1  valid when done=1; 1 if err_count==0
- err_count  output  N_IN+1  number of mismatching vectors in the last run
- first_fail_valid  output  1  at least one mismatch recorded
- first_fail_idx  output  N_IN  vec_out value of the first mismatch

Behaviour:
- Reset (asynchronous, active-high) forces all outputs to 0 and the FSM to IDLE immediately, including mid-run. Nothing from an aborted run is retained.
- Internal state:
  - step counter, width N_IN
  - hold counter, width 4
  - vec_out = step ^ (step >> 1)
- FSM states: IDLE, DRIVE, DONE.
- IDLE or DONE:
  - start=1 at edge T clears err_count, first_fail_valid, first_fail_idx, pass and done, and sets step=0, hold=0.
  - It then moves to DRIVE. From T+1: busy=1, vec_valid=1, vec_out=0.
- DRIVE:
  - Each vector is held for exactly SETTLE+1 cycles.
  - While hold < SETTLE: hold increments each cycle.
  - On the edge where hold == SETTLE: resp_in is sampled and compared with EXPECTED[vec_out].
  - On mismatch: err_count increments. If first_fail_valid==0, set first_fail_idx=vec_out and first_fail_valid=1 on the same edge.
  - If step == 2**N_IN-1, go to DONE. Otherwise step increments and hold returns to 0.
- DONE:
  - Entered on the final sample edge. From the next cycle: busy=0, vec_valid=0, vec_out=0, done=1.
  - pass = (final err_count == 0), with the final compare included.
  - Results hold until an accepted start or reset.
- Latency: done rises at T+1+2**N_IN*(SETTLE+1). With the defaults this is T+17.
- start while busy=1 is ignored. No effect on step, hold or counters.
- start in DONE restarts immediately. done drops the cycle after the start edge.
- err_count cannot overflow: its maximum value is 2**N_IN.
- resp_in is treated as synchronous to clk. resp_in is don't-care outside the sample edge.
- vec_out changes only at step boundaries, and only one bit changes per step (Gray order).
- Outside DRIVE, vec_out is driven to 0.

Test Plan:
- Golden run:
  - Setup: defaults; resp_in driven by the reference function of vec_out = {a,c,b}; start pulse.
  - Required vec_out sequence, each value held 2 cycles: 0,1,3,2,6,7,5,4.
  - At T+17: done=1, pass=1, err_count=0, first_fail_valid=0.
- Stuck-at-1 response:
  - Setup: resp_in=1 constant.
  - Required: err_count=2, first_fail_idx=3'b110 (step 4), first_fail_valid=1, pass=0.
- Stuck-at-0 response:
  - Setup: resp_in=0 constant.
  - Required: err_count=6, first_fail_idx=0, pass=0.
- Reset mid-run:
  - Stimulus: assert reset asynchronously (between clock edges) during step 3 with errors already counted.
  - Required during reset: all outputs 0 without waiting for a clock edge.
  - Required after release: IDLE with busy=0. A new start gives a full clean run.
- start handling:
  - start pulses during DRIVE: required to be ignored, with the vector sequence and timing unchanged.
  - start in DONE: done drops next cycle and vec_out restarts at 0.
- SETTLE=0 instance:
  - Required: one cycle per vector, done at T+9.
  - Required: a single-cycle glitch of resp_in on the step-5 vector (vec_out=7) is detected as exactly one error.
